rgfile_sb: RTL and testbench
============================

// Module: rgfile_sb
// PURPOSE
//  Parametrised Y86 register file for the pipelined core: NRD combinational read ports, two writeback ports (E, M),
//  optional write-to-read bypass, per-register pending-write scoreboard driving decode stalls, and a handshaked debug
//  dump walker. Sits in decode (reads, issue) and writeback (writes, retire); replaces the fixed 15x64 file.
// PARAMETERS
//  DATA_W  64  register width
//  NREG    15  architectural registers, IDs 0..NREG-1; ID 4'hF = RNONE (no register)
//  NRD     2   number of read ports
//  CNT_W   2   scoreboard counter width (max 2**CNT_W-1 in-flight writes per register)
//  BYPASS  1   1: read of a register written this cycle returns the write data; 0: returns old value
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rst        in   1           asynchronous, active-low reset
//  rd_id_i    in   NRD*4       read IDs, port k = [4k+3:4k]
//  rd_dat_o   out  NRD*DATA_W  read data, port k = [DATA_W*k +: DATA_W]; 0 for RNONE or ID>=NREG
//  rd_busy_o  out  NRD         port k register has pending count != 0 (0 for RNONE)
//  wE_id_i    in   4           writeback E destination (RNONE = no write)
//  wE_dat_i   in   DATA_W      writeback E data
//  wM_id_i    in   4           writeback M destination
//  wM_dat_i   in   DATA_W      writeback M data
//  iss_vld_i  in   1           decode issues an instruction with destinations below
//  iss_dstE_i in   4           issued E destination
//  iss_dstM_i in   4           issued M destination
//  iss_rdy_o  out  1           0 when either issued destination counter is saturated
//  dump_req_i in   1           pulse: start register dump (ignored unless walker IDLE)
//  dump_vld_o out  1           dump beat valid
//  dump_rdy_i in   1           consumer accepts beat
//  dump_idx_o out  4           register ID of current beat
//  dump_dat_o out  DATA_W      register value of current beat
//  dump_done_o out 1           one-cycle pulse after last beat accepted
//  err_o      out  1           sticky: scoreboard underflow or issue while !iss_rdy_o
// BEHAVIOUR
//  - Reset (rst=0, async): all registers 0, all counters 0, walker IDLE, dump_vld_o/dump_done_o/err_o 0, iss_rdy_o 1.
//  - Writes: both ports commit at clk edge. If wE_id_i==wM_id_i!=RNONE, M data wins. IDs >=NREG are ignored.
//  - Reads: combinational, zero latency. BYPASS=1: if rd_id matches wM_id then wM_dat, else wE_id then wE_dat,
//    else stored value. BYPASS=0: stored value only.
//  - Scoreboard: per register inc = iss_vld_i & iss_rdy_o & (iss_dstE_i==r | iss_dstM_i==r);
//    dec = (wE_id_i==r | wM_id_i==r). inc&dec: unchanged. dec on count 0: count stays 0, err_o set.
//    dstE==dstM counts once; retire on both ports to same reg counts once.
//  - iss_rdy_o = 0 if any non-RNONE issued dst has count == 2**CNT_W-1; issue with iss_rdy_o=0 is dropped, err_o set.
//  - rd_busy_o uses registered count (retire same cycle still shows busy; decode relies on forwarding).
//  - Dump FSM: IDLE -dump_req_i-> WALK (idx=0) ; WALK: dump_vld_o=1, holds idx/dat stable while !dump_rdy_i
//    (dat tracks live register incl. bypass per BYPASS); on accept idx++; accept at idx=NREG-1 -> DONE ;
//    DONE: dump_done_o=1 for one cycle -> IDLE. dump_req_i in WALK/DONE ignored. Writes continue during dump.
//  - Reset mid-dump aborts immediately: dump_vld_o drops asynchronously, no dump_done_o.
//  - err_o clears only on reset.
// STRUCTURE
//  - Shared package y86_pkg: register ID constants RAX..R14, RNONE=4'hF, default DATA_W; dump FSM state enum.
//  - One sub-module: sb_counter (CNT_W saturating up/down counter with inc, dec, underflow flag), one per register.
//  - Storage: generate loop of NREG enable registers; read muxes via generate over NRD.
// TESTING
//  1 reset: drive rst=0 mid-run with regs nonzero -> all rd_dat_o 0, rd_busy_o 0, iss_rdy_o 1, err_o 0.
//  2 write/read: wE RAX=0x11, wM RCX=0x22; next cycle rd RAX,RCX -> 0x11,0x22; wE=wM=RSP (0x5,0x9) -> RSP=0x9;
//    BYPASS=1 same-cycle read of RSP -> 0x9; BYPASS=0 -> old value.
//  3 scoreboard: issue dstE=RBX x3 (CNT_W=2) -> count 3, iss_rdy_o 0, rd_busy_o 1; retire RBX x3 -> busy 0;
//    issue+retire RBX same cycle -> count unchanged.
//  4 errors: retire RDX with count 0 -> err_o 1, count stays 0; issue while iss_rdy_o=0 -> dropped, err_o 1.
//  5 dump: preload reg i = 0x100+i; pulse dump_req_i, dump_rdy_i toggled 1/0 -> 15 beats idx 0..14,
//    dat 0x100..0x10E, stable while stalled, dump_done_o one cycle after beat 14.
//  6 reset during WALK at idx 7 -> dump_vld_o 0 immediately, no dump_done_o; new dump_req_i restarts at idx 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Y86 register IDs, default datapath width and dump-walker state encodings.
package y86_pkg;

    localparam logic [3:0] RAX   = 4'h0;
    localparam logic [3:0] RCX   = 4'h1;
    localparam logic [3:0] RDX   = 4'h2;
    localparam logic [3:0] RBX   = 4'h3;
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RBP   = 4'h5;
    localparam logic [3:0] RSI   = 4'h6;
    localparam logic [3:0] RDI   = 4'h7;
    localparam logic [3:0] R8    = 4'h8;
    localparam logic [3:0] R9    = 4'h9;
    localparam logic [3:0] R10   = 4'hA;
    localparam logic [3:0] R11   = 4'hB;
    localparam logic [3:0] R12   = 4'hC;
    localparam logic [3:0] R13   = 4'hD;
    localparam logic [3:0] R14   = 4'hE;
    localparam logic [3:0] RNONE = 4'hF;

    localparam int DATA_W_DEF = 64;

    localparam logic [1:0] DS_IDLE = 2'd0;
    localparam logic [1:0] DS_WALK = 2'd1;
    localparam logic [1:0] DS_DONE = 2'd2;

endpackage

// File: rtl/rgfile_sb_if.sv
// Debug dump channel of the register file: start pulse, valid/ready beat stream, done pulse.
interface rgfile_sb_if
    import y86_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              dump_req_i;
    logic              dump_vld_o;
    logic              dump_rdy_i;
    logic [3:0]        dump_idx_o;
    logic [DATA_W-1:0] dump_dat_o;
    logic              dump_done_o;

    modport master (
        output dump_req_i, dump_rdy_i,
        input  dump_vld_o, dump_idx_o, dump_dat_o, dump_done_o
    );

    modport slave (
        input  dump_req_i, dump_rdy_i,
        output dump_vld_o, dump_idx_o, dump_dat_o, dump_done_o
    );
endinterface

// File: rtl/sb_counter.sv
// Pending-write counter for one register: saturating up/down, simultaneous inc+dec cancels.
// Latency: count updates on the next clk edge; sat/underflow flags are combinational.
// Backpressure: none here, the owner must not inc while sat_o is high.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o,
    output logic             unf_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == CNT_MAX);
    assign unf_o = dec_i & ~inc_i & (cnt_q == '0);
endmodule

// File: rtl/rgfile_sb.sv
// Y86 register file with two writeback ports, optional write bypass, pending-write scoreboard and dump walker.
// Latency: reads and busy are combinational; writes, counters and walker update on the clk edge.
// Backpressure: iss_rdy_o drops on a saturated destination counter; dump beats hold while dump_rdy_i is low.
module rgfile_sb
    import y86_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = 15,
    parameter int NRD    = 2,
    parameter int CNT_W  = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*4-1:0]      rd_id_i,
    output logic [NRD*DATA_W-1:0] rd_dat_o,
    output logic [NRD-1:0]        rd_busy_o,
    input  logic [3:0]            wE_id_i,
    input  logic [DATA_W-1:0]     wE_dat_i,
    input  logic [3:0]            wM_id_i,
    input  logic [DATA_W-1:0]     wM_dat_i,
    input  logic                  iss_vld_i,
    input  logic [3:0]            iss_dstE_i,
    input  logic [3:0]            iss_dstM_i,
    output logic                  iss_rdy_o,
    output logic                  err_o,
    rgfile_sb_if.slave            dbg
);
    // Read port NRD is the dump walker's private port so it sees the same bypass.
    localparam int NPORT = NRD + 1;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy, sat, unf, inc, dec;
    logic [3:0]        pid  [NPORT];
    logic [DATA_W-1:0] pdat [NPORT];

    logic [1:0] st_q, st_d;
    logic [3:0] idx_q, idx_d;
    logic       err_q, err_d;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        logic [DATA_W-1:0] reg_q, reg_d;
        logic [CNT_W-1:0]  cnt;
        logic              we_e, we_m;

        assign we_e = (wE_id_i == 4'(r));
        assign we_m = (wM_id_i == 4'(r));

        always_comb begin
            reg_d = reg_q;
            if (we_e) reg_d = wE_dat_i;
            if (we_m) reg_d = wM_dat_i;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                reg_q <= '0;
            end else if (we_e || we_m) begin
                reg_q <= reg_d;
            end
        end

        assign regs[r] = reg_q;
        assign inc[r]  = iss_vld_i & iss_rdy_o &
                         ((iss_dstE_i == 4'(r)) | (iss_dstM_i == 4'(r)));
        assign dec[r]  = we_e | we_m;

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc_i (inc[r]),
            .dec_i (dec[r]),
            .cnt_o (cnt),
            .sat_o (sat[r]),
            .unf_o (unf[r])
        );

        assign busy[r] = (cnt != '0);
    end

    always_comb begin
        iss_rdy_o = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            if (sat[r] && (iss_dstE_i == 4'(r) || iss_dstM_i == 4'(r))) begin
                iss_rdy_o = 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign pid[k]                        = rd_id_i[4*k +: 4];
        assign rd_dat_o[DATA_W*k +: DATA_W]  = pdat[k];
        assign rd_busy_o[k]                  = (pid[k] < 4'(NREG)) && busy[pid[k]];
    end
    assign pid[NRD] = idx_q;

    for (genvar k = 0; k < NPORT; k++) begin : g_mux
        logic [DATA_W-1:0] dat;
        always_comb begin
            dat = '0;
            if (pid[k] < 4'(NREG)) begin
                dat = regs[pid[k]];
                if (BYPASS != 0) begin
                    if (pid[k] == wE_id_i) dat = wE_dat_i;
                    if (pid[k] == wM_id_i) dat = wM_dat_i;
                end
            end
        end
        assign pdat[k] = dat;
    end

    always_comb begin
        st_d  = st_q;
        idx_d = idx_q;
        case (st_q)
            DS_IDLE: begin
                if (dbg.dump_req_i) begin
                    st_d  = DS_WALK;
                    idx_d = '0;
                end
            end
            DS_WALK: begin
                if (dbg.dump_rdy_i) begin
                    if (idx_q == 4'(NREG - 1)) begin
                        st_d  = DS_DONE;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DS_DONE: st_d = DS_IDLE;
            default: st_d = DS_IDLE;
        endcase
    end

    assign err_d = err_q | (|unf) | (iss_vld_i & ~iss_rdy_o);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q  <= DS_IDLE;
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    assign err_o           = err_q;
    assign dbg.dump_vld_o  = (st_q == DS_WALK);
    assign dbg.dump_done_o = (st_q == DS_DONE);
    assign dbg.dump_idx_o  = idx_q;
    assign dbg.dump_dat_o  = pdat[NRD];
endmodule

// File: tb/tb_rgfile_sb.sv
// Bench for rgfile_sb: BYPASS=1 and BYPASS=0 instances driven in lockstep.
module tb_rgfile_sb;
    import y86_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [7:0]   rd_id;
    logic [127:0] rd_dat1, rd_dat0;
    logic [1:0]   busy1, busy0;
    logic [3:0]   we_id, wm_id, dst_e, dst_m;
    logic [63:0]  we_dat, wm_dat;
    logic         iss_vld, rdy1, rdy0, err1, err0;

    rgfile_sb_if #(.DATA_W(64)) dbg1 ();
    rgfile_sb_if #(.DATA_W(64)) dbg0 ();

    rgfile_sb #(.BYPASS(1)) u_dut1 (
        .clk(clk), .rst(rst), .rd_id_i(rd_id), .rd_dat_o(rd_dat1), .rd_busy_o(busy1),
        .wE_id_i(we_id), .wE_dat_i(we_dat), .wM_id_i(wm_id), .wM_dat_i(wm_dat),
        .iss_vld_i(iss_vld), .iss_dstE_i(dst_e), .iss_dstM_i(dst_m), .iss_rdy_o(rdy1),
        .err_o(err1), .dbg(dbg1)
    );

    rgfile_sb #(.BYPASS(0)) u_dut0 (
        .clk(clk), .rst(rst), .rd_id_i(rd_id), .rd_dat_o(rd_dat0), .rd_busy_o(busy0),
        .wE_id_i(we_id), .wE_dat_i(we_dat), .wM_id_i(wm_id), .wM_dat_i(wm_dat),
        .iss_vld_i(iss_vld), .iss_dstE_i(dst_e), .iss_dstM_i(dst_m), .iss_rdy_o(rdy0),
        .err_o(err0), .dbg(dbg0)
    );

    typedef struct {
        logic [3:0]  we_id;
        logic [63:0] we_dat;
        logic [3:0]  wm_id;
        logic [63:0] wm_dat;
        logic [3:0]  r0, r1;
        logic [63:0] e0_b1, e1_b1, e0_b0, e1_b0;
    } vec_t;

    typedef struct {
        logic [3:0]  idx;
        logic [63:0] dat;
    } beat_t;

    vec_t  vecs [10];
    beat_t sb_q [$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_id   = RNONE; we_dat = '0;
        wm_id   = RNONE; wm_dat = '0;
        iss_vld = 1'b0;  dst_e  = RNONE; dst_m = RNONE;
    endtask

    task automatic set_dump(input logic req, input logic rdy);
        dbg1.dump_req_i = req; dbg1.dump_rdy_i = rdy;
        dbg0.dump_req_i = req; dbg0.dump_rdy_i = rdy;
    endtask

    initial begin
        int beats, cyc, dones;
        beat_t b;

        vecs[0] = '{RAX,   64'h11, RCX,   64'h22, RAX, RCX,   64'h11, 64'h22, 64'h0,  64'h0};
        vecs[1] = '{RNONE, 64'h0,  RNONE, 64'h0,  RAX, RCX,   64'h11, 64'h22, 64'h11, 64'h22};
        vecs[2] = '{RSP,   64'h5,  RSP,   64'h9,  RSP, RNONE, 64'h9,  64'h0,  64'h0,  64'h0};
        vecs[3] = '{RNONE, 64'h0,  RNONE, 64'h0,  RSP, RDX,   64'h9,  64'h0,  64'h9,  64'h0};
        vecs[4] = '{RBX,   64'h33, RNONE, 64'h0,  RBX, RNONE, 64'h33, 64'h0,  64'h0,  64'h0};
        vecs[5] = '{RNONE, 64'h0,  RNONE, 64'h0,  RBX, RSP,   64'h33, 64'h9,  64'h33, 64'h9};
        vecs[6] = '{RAX,   64'hAA, RBX,   64'hBB, RAX, RBX,   64'hAA, 64'hBB, 64'h11, 64'h33};
        vecs[7] = '{RNONE, 64'h0,  RNONE, 64'h0,  RAX, RBX,   64'hAA, 64'hBB, 64'hAA, 64'hBB};
        vecs[8] = '{RNONE, 64'h0,  R14,   64'hEE, R14, RSP,   64'hEE, 64'h9,  64'h0,  64'h9};
        vecs[9] = '{RNONE, 64'h0,  RNONE, 64'h0,  R14, RCX,   64'hEE, 64'h22, 64'hEE, 64'h22};

        rst = 1'b0;
        idle();
        rd_id = {RCX, RAX};
        set_dump(1'b0, 1'b0);
        #12;
        chk("reset rd_dat", rd_dat1, 128'h0);
        chk("reset busy", busy1, 2'b00);
        chk("reset iss_rdy", rdy1, 1'b1);
        chk("reset err", err1, 1'b0);
        chk("reset dump_vld", dbg1.dump_vld_o, 1'b0);
        chk("reset dump_done", dbg1.dump_done_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // write/read vectors, checked in the same cycle so bypass is visible
        for (int i = 0; i < 10; i++) begin
            we_id = vecs[i].we_id; we_dat = vecs[i].we_dat;
            wm_id = vecs[i].wm_id; wm_dat = vecs[i].wm_dat;
            rd_id = {vecs[i].r1, vecs[i].r0};
            #1;
            chk($sformatf("vec%0d bypass p0", i), rd_dat1[63:0],   vecs[i].e0_b1);
            chk($sformatf("vec%0d bypass p1", i), rd_dat1[127:64], vecs[i].e1_b1);
            chk($sformatf("vec%0d nobyp p0", i),  rd_dat0[63:0],   vecs[i].e0_b0);
            chk($sformatf("vec%0d nobyp p1", i),  rd_dat0[127:64], vecs[i].e1_b0);
            step();
        end
        idle();

        // underflow sets err, then reset mid-run clears everything
        iss_vld = 1'b1; dst_e = RAX;
        we_id = RDX; we_dat = 64'h77;
        rd_id = {RDX, RAX};
        #1;
        chk("pre-issue iss_rdy", rdy1, 1'b1);
        step();
        idle();
        #1;
        chk("issued busy", busy1, 2'b01);
        chk("underflow err", err1, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrun reset rd_dat", rd_dat1, 128'h0);
        chk("midrun reset busy", busy1, 2'b00);
        chk("midrun reset iss_rdy", rdy1, 1'b1);
        chk("midrun reset err", err1, 1'b0);
        chk("midrun reset err nobyp", err0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // saturate RBX, drop an issue, then retire with an issue+retire cycle in the middle
        rd_id = {RNONE, RBX};
        for (int i = 0; i < 3; i++) begin
            iss_vld = 1'b1; dst_e = RBX;
            #1;
            chk($sformatf("issue%0d iss_rdy", i), rdy1, 1'b1);
            step();
        end
        iss_vld = 1'b0;
        #1;
        chk("saturated iss_rdy", rdy1, 1'b0);
        chk("saturated busy", busy1[0], 1'b1);
        chk("no err before drop", err1, 1'b0);
        iss_vld = 1'b1;
        step();
        iss_vld = 1'b0;
        #1;
        chk("dropped issue err", err1, 1'b1);
        chk("dropped issue count", rdy1, 1'b0);
        we_id = RBX;
        #1;
        chk("retire cycle busy", busy1[0], 1'b1);
        step();
        idle();
        dst_e = RBX;
        #1;
        chk("count2 iss_rdy", rdy1, 1'b1);
        iss_vld = 1'b1; we_id = RBX;
        step();
        idle();
        we_id = RBX;
        step();
        idle();
        #1;
        chk("count1 busy", busy1[0], 1'b1);
        we_id = RBX;
        step();
        idle();
        #1;
        chk("count0 busy", busy1[0], 1'b0);

        iss_vld = 1'b1; dst_e = RSI; dst_m = RSI;
        step();
        idle();
        rd_id = {RNONE, RSI};
        #1;
        chk("dstE=dstM busy", busy1[0], 1'b1);
        we_id = RSI;
        step();
        idle();
        #1;
        chk("dstE=dstM single retire", busy1[0], 1'b0);

        rd_id = {RNONE, RDI};
        for (int i = 0; i < 2; i++) begin
            iss_vld = 1'b1; dst_e = RDI;
            step();
        end
        idle();
        we_id = RDI; wm_id = RDI;
        step();
        idle();
        #1;
        chk("dual retire counts once", busy1[0], 1'b1);
        we_id = RDI; wm_id = RDI;
        step();
        idle();
        #1;
        chk("dual retire drained", busy1[0], 1'b0);

        // dump with a stalling consumer
        for (int i = 0; i < 15; i++) begin
            we_id = 4'(i); we_dat = 64'h100 + 64'(i);
            step();
        end
        idle();
        for (int i = 0; i < 15; i++) begin
            b.idx = 4'(i);
            b.dat = 64'h100 + 64'(i);
            sb_q.push_back(b);
        end
        set_dump(1'b1, 1'b0);
        step();
        beats = 0; cyc = 0; dones = 0;
        while (beats < 15 && cyc < 100) begin
            set_dump(1'b0, cyc[0]);
            #1;
            if (dbg1.dump_done_o) dones++;
            chk("walk dump_vld", dbg1.dump_vld_o, 1'b1);
            if (dbg1.dump_vld_o && sb_q.size() > 0) begin
                chk($sformatf("beat%0d idx", beats), dbg1.dump_idx_o, sb_q[0].idx);
                chk($sformatf("beat%0d dat", beats), dbg1.dump_dat_o, sb_q[0].dat);
                if (dbg1.dump_rdy_i) begin
                    void'(sb_q.pop_front());
                    beats++;
                end
            end
            step();
            cyc++;
        end
        chk("dump beat count", beats, 15);
        set_dump(1'b0, 1'b0);
        #1;
        if (dbg1.dump_done_o) dones++;
        chk("dump_done after last beat", dbg1.dump_done_o, 1'b1);
        chk("dump_vld in done", dbg1.dump_vld_o, 1'b0);
        step();
        if (dbg1.dump_done_o) dones++;
        chk("dump_done one cycle", dbg1.dump_done_o, 1'b0);
        chk("dump_done pulse count", dones, 1);

        // reset during walk aborts, new request restarts from 0
        set_dump(1'b1, 1'b1);
        step();
        set_dump(1'b0, 1'b1);
        cyc = 0;
        while (cyc < 40) begin
            #1;
            if (dbg1.dump_idx_o == 4'd7) break;
            step();
            cyc++;
        end
        chk("walk reached idx7", dbg1.dump_idx_o, 4'd7);
        rst = 1'b0;
        #1;
        chk("abort dump_vld", dbg1.dump_vld_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dbg1.dump_done_o || dbg1.dump_vld_o) dones++;
        end
        chk("no done/vld after abort", dones, 0);
        set_dump(1'b1, 1'b0);
        step();
        set_dump(1'b0, 1'b0);
        #1;
        chk("restart dump_vld", dbg1.dump_vld_o, 1'b1);
        chk("restart idx", dbg1.dump_idx_o, 4'd0);
        chk("restart dat", dbg1.dump_dat_o, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
